// File: rtl/eth_pkt_pkg.sv
// Shared Ethernet/IPv4 packet constants and types.
// Used by the IPv4 ingress filter and its header checker.
package eth_pkt_pkg;

    localparam int PKT_DW       = 512;
    localparam int ETYPE_OFS    = 12;
    localparam int IP_OFS       = 14;
    localparam int IPLEN_OFS    = 16;
    localparam int IPCSUM_OFS   = 24;
    localparam int IP_HDR_WORDS = 10;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [15:0] IP_MIN_LEN     = 16'd20;

    typedef enum logic [2:0] {
        DR_NONE    = 3'd0,
        DR_ETYPE   = 3'd1,
        DR_VER_IHL = 3'd2,
        DR_LEN     = 3'd3,
        DR_CSUM    = 3'd4
    } drop_reason_t;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } filt_state_t;

    // Big-endian 16-bit field at byte offset ofs (byte n is lane n).
    function automatic logic [15:0] be16(
        input logic [PKT_DW-1:0] d,
        input int                ofs
    );
        return {d[8*ofs +: 8], d[8*(ofs+1) +: 8]};
    endfunction

endpackage

// File: rtl/ipv4_hdr_check.sv
// Combinational EtherType / IPv4 header verdict for a header beat.
// Checks are prioritised; pass is high only when no check fails.
module ipv4_hdr_check
    import eth_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int MAX_IP_LEN = 2034
) (
    input  logic [DATA_WIDTH-1:0] hdr,
    output logic                  pass,
    output drop_reason_t          reason
);

    logic [15:0] w_etype;
    logic [7:0]  w_ver_ihl;
    logic [15:0] w_len;
    logic [31:0] w_sum;
    logic [16:0] w_fold;
    logic [15:0] w_csum;

    assign w_etype   = be16(hdr, ETYPE_OFS);
    assign w_ver_ihl = hdr[8*IP_OFS +: 8];
    assign w_len     = be16(hdr, IPLEN_OFS);

    // Plain sum of the ten header words; carries folded below.
    always_comb begin
        w_sum = 32'd0;
        for (int i = 0; i < IP_HDR_WORDS; i++) begin
            w_sum = w_sum + {16'd0, be16(hdr, IP_OFS + 2*i)};
        end
    end

    assign w_fold = {1'b0, w_sum[15:0]} + {1'b0, w_sum[31:16]};
    assign w_csum = w_fold[15:0] + {15'd0, w_fold[16]};

    // First failing check wins.
    always_comb begin
        reason = DR_NONE;
        if (w_etype != ETHERTYPE_IPV4) begin
            reason = DR_ETYPE;
        end else if (w_ver_ihl != IPV4_VER_IHL) begin
            reason = DR_VER_IHL;
        end else if (w_len < IP_MIN_LEN || w_len > 16'(MAX_IP_LEN)) begin
            reason = DR_LEN;
        end else if (w_csum != 16'hFFFF) begin
            reason = DR_CSUM;
        end
    end

    assign pass = (reason == DR_NONE);

endmodule

// File: rtl/eth_ipv4_filter.sv
// IPv4 ingress filter: forwards valid IPv4 frames, discards the rest.
// One output register stage; full throughput with 1-cycle latency.
module eth_ipv4_filter
    import eth_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int MAX_IP_LEN = 2034
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           pkt_pass_cnt,
    output logic [31:0]           pkt_drop_cnt,
    output logic [2:0]            last_drop_reason
);

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    filt_state_t           r_state;
    filt_state_t           w_next;
    logic                  w_pass;
    drop_reason_t          w_reason;
    logic                  w_s_ready;
    logic                  w_acc;
    logic                  w_hdr_acc;
    logic                  w_fwd;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [31:0]           r_pass_cnt;
    logic [31:0]           r_drop_cnt;
    drop_reason_t          r_last_reason;

    ipv4_hdr_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_IP_LEN (MAX_IP_LEN)
    ) u_chk (
        .hdr    (s_axis_tdata),
        .pass   (w_pass),
        .reason (w_reason)
    );

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // FSM state register.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state: a header picks pass/drop, tlast returns to S_HDR.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_HDR: begin
                if (w_acc && !s_axis_tlast) begin
                    w_next = w_pass ? S_PASS : S_DROP;
                end
            end
            S_PASS, S_DROP: begin
                if (w_acc && s_axis_tlast) begin
                    w_next = S_HDR;
                end
            end
            default: w_next = S_HDR;
        endcase
    end

    // FSM outputs: input ready, header accept and forward strobes.
    always_comb begin
        w_s_ready = 1'b0;
        if (w_rst_n) begin
            unique case (r_state)
                S_DROP:  w_s_ready = 1'b1;
                default: w_s_ready = !r_tvalid || m_axis_tready;
            endcase
        end
        w_acc     = s_axis_tvalid && w_s_ready;
        w_hdr_acc = w_acc && (r_state == S_HDR);
        w_fwd     = w_acc && ((r_state == S_PASS) ||
                              ((r_state == S_HDR) && w_pass));
    end

    // Output data register; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_fwd) begin
            r_tdata <= s_axis_tdata;
        end
    end

    // Output valid/last; held while downstream stalls.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_fwd) begin
            r_tvalid <= 1'b1;
            r_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    // Per-frame statistics, updated on each accepted header beat.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pass_cnt    <= 32'd0;
            r_drop_cnt    <= 32'd0;
            r_last_reason <= DR_NONE;
        end else if (w_hdr_acc) begin
            if (w_pass) begin
                r_pass_cnt <= r_pass_cnt + 32'd1;
            end else begin
                r_drop_cnt    <= r_drop_cnt + 32'd1;
                r_last_reason <= w_reason;
            end
        end
    end

    assign s_axis_tready    = w_s_ready;
    assign m_axis_tdata     = r_tdata;
    assign m_axis_tvalid    = r_tvalid;
    assign m_axis_tlast     = r_tlast;
    assign pkt_pass_cnt     = r_pass_cnt;
    assign pkt_drop_cnt     = r_drop_cnt;
    assign last_drop_reason = r_last_reason;

endmodule

// File: tb/tb_eth_ipv4_filter.sv
// Scoreboard bench for eth_ipv4_filter.
// Stimulus pushes expected beats; a monitor pops and compares.
module tb_eth_ipv4_filter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [511:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic [31:0]  pass_cnt;
    logic [31:0]  drop_cnt;
    logic [2:0]   reason;

    typedef struct {
        logic [511:0] d;
        logic         l;
        int           c;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    eth_ipv4_filter #(
        .DATA_WIDTH (512),
        .MAX_IP_LEN (2034)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_tdata),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .s_axis_tlast     (s_tlast),
        .m_axis_tdata     (m_tdata),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tready    (m_tready),
        .m_axis_tlast     (m_tlast),
        .pkt_pass_cnt     (pass_cnt),
        .pkt_drop_cnt     (drop_cnt),
        .last_drop_reason (reason)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic summary_fatal(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "aborted");
    endtask

    function automatic logic [511:0] mk_hdr(input logic [15:0] et,
        input logic [7:0] vi, input logic [15:0] len, input logic [15:0] cs);
        logic [7:0]   b [64];
        logic [511:0] d;
        for (int i = 0; i < 64; i++) b[i] = 8'(i + 16);
        b[12] = et[15:8];  b[13] = et[7:0];
        b[14] = vi;        b[15] = 8'h00;
        b[16] = len[15:8]; b[17] = len[7:0];
        b[18] = 8'h00;     b[19] = 8'h00;
        b[20] = 8'h40;     b[21] = 8'h00;
        b[22] = 8'h40;     b[23] = 8'h11;
        b[24] = cs[15:8];  b[25] = cs[7:0];
        b[26] = 8'hC0; b[27] = 8'hA8; b[28] = 8'h00; b[29] = 8'h01;
        b[30] = 8'hC0; b[31] = 8'hA8; b[32] = 8'h00; b[33] = 8'hC7;
        d = '0;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = b[i];
        return d;
    endfunction

    function automatic logic [511:0] pl(input int k);
        return {16{32'hA5000000 | 32'(k)}};
    endfunction

    // Present one beat (entered just after a posedge), wait for accept.
    task automatic send(input logic [511:0] d, input logic l,
                        input bit fwd, input bit lat, output int waited);
        exp_t e;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!s_tready) begin
            waited++;
            if (waited > 200) summary_fatal("send_wait");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        if (fwd) begin
            e.d = d;
            e.l = l;
            e.c = lat ? cyc : -1;
            q.push_back(e);
        end
    endtask

    task automatic drain;
        int n = 0;
        while (q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 50) summary_fatal("drain");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string nm, input int ep, input int ed,
                             input int er);
        chk({nm, "_pass_cnt"}, pass_cnt, ep);
        chk({nm, "_drop_cnt"}, drop_cnt, ed);
        chk({nm, "_reason"}, reason, er);
    endtask

    logic         mon_stall = 1'b0;
    logic [511:0] mon_d;
    logic         mon_l;

    // Monitor: stability under backpressure, then scoreboard pop.
    always @(negedge clk) begin
        exp_t e;
        if (mon_stall && rst_n) begin
            chk("hold_valid", m_tvalid, 1'b1);
            chk("hold_data", m_tdata, mon_d);
            chk("hold_last", m_tlast, mon_l);
        end
        mon_stall = m_tvalid && !m_tready;
        mon_d     = m_tdata;
        mon_l     = m_tlast;
        if (m_tvalid && m_tready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", m_tdata, '0);
            end else begin
                e = q.pop_front();
                chk("out_data", m_tdata, e.d);
                chk("out_last", m_tlast, e.l);
                if (e.c >= 0) chk("out_latency_cyc", cyc, e.c);
            end
        end
    end

    initial begin
        #200000;
        summary_fatal("global_timeout");
    end

    initial begin
        logic [511:0] good;
        int w;
        int w2;
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;
        good = mk_hdr(16'h0800, 8'h45, 16'h0073, 16'hB861);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tlast", m_tlast, 1'b0);
        chk_stats("rst", 0, 0, 0);
        rst_n = 1'b1;

        // Valid 3-beat frame.
        send(good, 1'b0, 1'b1, 1'b1, w);
        send(pl(1), 1'b0, 1'b1, 1'b1, w);
        send(pl(2), 1'b1, 1'b1, 1'b1, w);
        drain();
        chk_stats("good", 1, 0, 0);

        // Bad checksum: always ready, nothing out.
        send(mk_hdr(16'h0800, 8'h45, 16'h0073, 16'hB862), 1'b0, 1'b0, 1'b0, w);
        chk("csum_rdy0", w, 0);
        send(pl(3), 1'b0, 1'b0, 1'b0, w);
        chk("csum_rdy1", w, 0);
        send(pl(4), 1'b1, 1'b0, 1'b0, w);
        chk("csum_rdy2", w, 0);
        drain();
        chk_stats("csum", 1, 1, 4);

        // IPv6 frame immediately followed by a good frame.
        send(mk_hdr(16'h86DD, 8'h60, 16'h0073, 16'hB861), 1'b0, 1'b0, 1'b0, w);
        send(pl(5), 1'b1, 1'b0, 1'b0, w);
        send(good, 1'b0, 1'b1, 1'b1, w);
        chk("b2b_no_gap", w, 0);
        send(pl(6), 1'b0, 1'b1, 1'b1, w);
        send(pl(7), 1'b1, 1'b1, 1'b1, w);
        drain();
        chk_stats("b2b", 2, 2, 1);

        // Single-beat frames: bad version/IHL, too-short length.
        send(mk_hdr(16'h0800, 8'h46, 16'h0073, 16'hB761), 1'b1, 1'b0, 1'b0, w);
        chk_stats("verihl", 2, 3, 2);
        send(mk_hdr(16'h0800, 8'h45, 16'h0013, 16'hB8C1), 1'b1, 1'b0, 1'b0, w);
        chk_stats("len_short", 2, 4, 3);

        // Length boundary: 2035 drops, 2034 passes.
        send(mk_hdr(16'h0800, 8'h45, 16'h07F3, 16'hB0E1), 1'b0, 1'b0, 1'b0, w);
        send(pl(8), 1'b1, 1'b0, 1'b0, w);
        chk_stats("len_2035", 2, 5, 3);
        send(mk_hdr(16'h0800, 8'h45, 16'h07F2, 16'hB0E2), 1'b1, 1'b1, 1'b1, w);
        drain();
        chk_stats("len_2034", 3, 5, 3);

        // Downstream stall for 5 cycles mid-frame.
        fork
            begin
                send(good, 1'b0, 1'b1, 1'b0, w);
                send(pl(9), 1'b0, 1'b1, 1'b0, w);
                send(pl(10), 1'b0, 1'b1, 1'b0, w);
                send(pl(11), 1'b1, 1'b1, 1'b0, w);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                m_tready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_s_tready", s_tready, 1'b0);
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();
        chk_stats("stall", 4, 5, 3);

        // Reset during beat 2 of a 4-beat frame.
        send(good, 1'b0, 1'b1, 1'b1, w);
        send(pl(1), 1'b0, 1'b0, 1'b0, w);
        s_tdata  = pl(2);
        s_tvalid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst_mid_tvalid", m_tvalid, 1'b0);
        chk("rst_mid_s_tready", s_tready, 1'b0);
        chk_stats("rst_mid", 0, 0, 0);
        s_tvalid = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(pl(2), 1'b0, 1'b0, 1'b0, w);
        send(pl(3), 1'b1, 1'b0, 1'b0, w2);
        repeat (3) @(posedge clk);
        #1;
        chk_stats("post_rst", 0, 1, 1);
        chk("post_rst_idle", m_tvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_ipv4_filter.md
ETH_IPV4_FILTER -- requirements
Module: eth_ipv4_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, stream data width in bits; only 512 is supported.
REQ-002 SHALL have parameter MAX_IP_LEN, default 2034, largest accepted IPv4 total length in bytes.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports s_axis_tdata/tvalid/tready/tlast, in/in/out/in, DATA_WIDTH/1/1/1, Ethernet frame input.
REQ-006 SHALL have ports m_axis_tdata/tvalid/tready/tlast, out/out/in/out, DATA_WIDTH/1/1/1, filtered frame output to the DDR writer.
REQ-007 SHALL have port pkt_pass_cnt, output, 32, count of forwarded frames.
REQ-008 SHALL have port pkt_drop_cnt, output, 32, count of dropped frames.
REQ-009 SHALL have port last_drop_reason, output, 3, reason for the most recent drop (NONE/ETYPE/VER_IHL/LEN/CSUM).

Function
REQ-010 SHALL map frame byte n to tdata[8n+7:8n]; multi-byte fields are big-endian, with the first byte in the lower lane.
REQ-011 SHALL run state machine S_HDR (next beat is a header), S_PASS (forwarding) and S_DROP (discarding), and SHALL reset into S_HDR.
REQ-012 SHALL evaluate the verdict combinationally on the accepted S_HDR beat; the IPv4 header is bytes 14..33, wholly inside beat 0.
REQ-013 SHALL apply these drop checks in priority order:
- ETYPE: bytes 12-13 != 0x0800.
- VER_IHL: byte 14 != 0x45.
- LEN: total length (bytes 16-17) < 20 or > MAX_IP_LEN.
- CSUM: ones-complement sum of the ten 16-bit header words != 0xFFFF.
REQ-014 SHALL compute the checksum with end-around carry folding to 16 bits.
REQ-015 SHALL drive s_axis_tready = 1 in S_DROP, and !m_axis_tvalid || m_axis_tready otherwise.
REQ-016 SHALL load a passing beat into the output register on the accept cycle, giving 1-cycle latency and no bubbles at full throughput.
REQ-017 SHALL never present a failing header beat or any of its subsequent beats on m_axis.
REQ-018 On a passing header: S_HDR->S_PASS if tlast=0; stay in S_HDR if tlast=1.
REQ-019 On a failing header: S_HDR->S_DROP if tlast=0; stay in S_HDR if tlast=1.
REQ-020 SHALL return S_PASS->S_HDR and S_DROP->S_HDR on an accepted beat with tlast=1.
REQ-021 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 SHALL increment pkt_pass_cnt on acceptance of a passing header beat, and pkt_drop_cnt and last_drop_reason on acceptance of a failing header beat.
REQ-023 SHALL let the 32-bit counters wrap from 0xFFFFFFFF to 0.
REQ-024 SHALL treat a frame ending on its header beat (tlast on beat 0) as a complete frame.
REQ-025 SHALL NOT compare total length against the beat count; length conformity is the downstream writer's responsibility.

Reset
REQ-026 SHALL on rst_n low asynchronously clear m_axis_tvalid, m_axis_tlast, both counters and last_drop_reason (to NONE), and force S_HDR.
REQ-027 SHALL leave m_axis_tdata uninitialised by reset.
REQ-028 SHALL release reset synchronously to clk.
REQ-029 SHALL treat the first accepted beat after reset as a header, even if a frame was interrupted mid-way.

Structure
REQ-030 SHALL take from shared package eth_pkt_pkg:
- byte-offset constants (ETYPE_OFS=12, IP_OFS=14, IPLEN_OFS=16, IPCSUM_OFS=24);
- ETHERTYPE_IPV4;
- the drop_reason_t enum;
- the filter state enum.
REQ-031 SHALL place the header checks and checksum in combinational sub-module ipv4_hdr_check, outputs pass and reason.

Verification
REQ-032 Valid frame, header 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7, EtherType 0x0800, 3 beats -> 3 identical beats out, 1 cycle later; pkt_pass_cnt=1.
REQ-033 Same frame with checksum B862 -> no m_axis beats; tready=1 for all 3 beats; pkt_drop_cnt=1; reason=CSUM.
REQ-034 EtherType 0x86DD followed immediately by the REQ-032 frame -> first dropped (ETYPE), second forwarded intact with no gap between the frames.
REQ-035 Total length 0x07F3 (2035) -> dropped, reason=LEN; 0x07F2 -> forwarded.
REQ-036 m_axis_tready held low 5 cycles mid-frame -> output held stable, s_axis_tready=0, no beat lost or duplicated.
REQ-037 rst_n pulsed low during beat 2 of a 4-beat frame -> m_axis_tvalid=0 immediately; the next beat is parsed as a header and, failing EtherType, is dropped.
